mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one native-handshake memory port between the picorv32 core bus and the vector coprocessor load/store bus (picorv32_pcpi_vec). It sits in final_module between both masters and the single memory model. Grants are round-robin, held until the memory completes, with a back-to-back handoff and an optional watchdog that terminates transfers the memory never answers.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 21 ++
 rtl/mem_arb_rr_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// state encoding, requester IDs and the data returned on a forced completion.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GNT_CPU = 2'd1;
    localparam logic [1:0] ST_GNT_VEC = 2'd2;

    typedef enum logic [0:0] {
        REQ_CPU = 1'b0,
        REQ_VEC = 1'b1
    } req_id_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

    function automatic logic [1:0] req_onehot(input req_id_e id);
        return (id == REQ_CPU) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Native picorv32-style memory handshake bundle; master drives the request,
// slave answers with ready/rdata.
interface mem_port_arbiter_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way round-robin picker: among valid, non-excluded
// requesters, a tie goes to the one that was not granted last.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  req_id_e    last_grant_i,
    input  logic [1:0] exclude_i,
    output logic [1:0] grant_o
);

    logic [1:0] cand_s;

    assign cand_s = valid_i & ~exclude_i;

    // Pick one candidate, alternating on a tie
    always_comb begin
        grant_o = 2'b00;
        case (cand_s)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ~req_onehot(last_grant_i);
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core bus and the vector load/store bus.
// Optional watchdog on unanswered transfers: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   cpu,
    mem_port_arbiter_if.slave   vec,
    mem_port_arbiter_if.master  mem,
    output logic                timeout_err
);

    logic [1:0]  state_q, state_d;
    req_id_e     last_q, last_d;
    logic        valid_q, valid_d;
    logic        instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic        granted_s;
    logic        serve_cpu_s;
    logic        serve_vec_s;
    logic        timeout_hit_s;
    logic        completion_s;
    logic        arbitrate_s;
    logic [1:0]  exclude_s;
    logic [1:0]  grant_s;

    assign granted_s    = (state_q != ST_IDLE);
    assign serve_cpu_s  = (state_q == ST_GNT_CPU);
    assign serve_vec_s  = (state_q == ST_GNT_VEC);
    assign completion_s = granted_s && (mem.mem_ready || timeout_hit_s);
    assign arbitrate_s  = !granted_s || completion_s;
    // The just-served requester still shows valid during its completion cycle
    assign exclude_s    = !completion_s ? 2'b00 :
                          (serve_cpu_s ? 2'b01 : 2'b10);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    assign timeout_hit_s = granted_s && !mem.mem_ready &&
                           (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count granted cycles without a memory answer; restart on every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (!granted_s || completion_s) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    mem_arb_rr_pick u_pick (
        .valid_i      ({vec.mem_valid, cpu.mem_valid}),
        .last_grant_i (last_q),
        .exclude_i    (exclude_s),
        .grant_o      (grant_s)
    );

    // Next grant and request-field latching
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (arbitrate_s) begin
            case (grant_s)
                2'b01: begin
                    state_d = ST_GNT_CPU;
                    last_d  = REQ_CPU;
                    instr_d = cpu.mem_instr;
                    addr_d  = cpu.mem_addr;
                    wdata_d = cpu.mem_wdata;
                    wstrb_d = cpu.mem_wstrb;
                end
                2'b10: begin
                    state_d = ST_GNT_VEC;
                    last_d  = REQ_VEC;
                    instr_d = 1'b0;
                    addr_d  = vec.mem_addr;
                    wdata_d = vec.mem_wdata;
                    wstrb_d = vec.mem_wstrb;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
        valid_d = (state_d != ST_IDLE);
    end

    // Arbiter state and downstream request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= REQ_VEC;
            valid_q <= 1'b0;
            instr_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign mem.mem_valid = valid_q;
    assign mem.mem_instr = instr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;

    assign cpu.mem_ready = completion_s && serve_cpu_s;
    assign vec.mem_ready = completion_s && serve_vec_s;
    assign cpu.mem_rdata = (timeout_hit_s && serve_cpu_s) ? TIMEOUT_RDATA : mem.mem_rdata;
    assign vec.mem_rdata = (timeout_hit_s && serve_vec_s) ? TIMEOUT_RDATA : mem.mem_rdata;
    assign timeout_err   = timeout_hit_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a single-cycle
// memory model and a transfer-level reference (optional MEM_ARB_TIMEOUT_EN).
module tb_mem_port_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic timeout_err;
    logic force_ready = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if cpu_if ();
    mem_port_arbiter_if vec_if ();
    mem_port_arbiter_if mem_if ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu         (cpu_if),
        .vec         (vec_if),
        .mem         (mem_if),
        .timeout_err (timeout_err)
    );

    // Single-cycle memory; addresses at or above 2048 are never answered
    logic [31:0] mem_arr [0:511];
    logic [31:0] ref_mem [0:511];
    logic        ready_q;
    logic [31:0] rdata_q;

    assign mem_if.mem_ready = ready_q | force_ready;
    assign mem_if.mem_rdata = rdata_q;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ready_q <= 1'b0;
            if (mem_if.mem_valid && !ready_q && mem_if.mem_addr < 32'd2048) begin
                ready_q <= 1'b1;
                rdata_q <= mem_arr[mem_if.mem_addr[10:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_if.mem_wstrb[b])
                        mem_arr[mem_if.mem_addr[10:2]][8*b +: 8] <= mem_if.mem_wdata[8*b +: 8];
            end
        end
    end

    int n_assert = 0;
    int n_fail = 0;
    int exp_next = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic v, input logic ins, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] ws);
        cpu_if.mem_valid = v;
        cpu_if.mem_instr = ins;
        cpu_if.mem_addr  = a;
        cpu_if.mem_wdata = wd;
        cpu_if.mem_wstrb = ws;
    endtask

    task automatic drive_vec(input logic v, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] ws);
        vec_if.mem_valid = v;
        vec_if.mem_instr = 1'b0;
        vec_if.mem_addr  = a;
        vec_if.mem_wdata = wd;
        vec_if.mem_wstrb = ws;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        force_ready = 1'b0;
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_vec(1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Random request: half reads, half writes with a nonzero strobe
    task automatic rand_req(output logic [31:0] a, output logic [31:0] wd, output logic [3:0] ws);
        a  = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
        wd = $urandom;
        ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endtask

    // Reference effect of one completed transfer
    task automatic on_ready(input int id, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [31:0] rd);
        if (exp_next >= 0) chk("rr_order", 32'(id), 32'(exp_next));
        if (ws == 4'h0) begin
            chk(id == 0 ? "cpu_rdata" : "vec_rdata", rd, ref_mem[a[10:2]]);
        end else begin
            for (int b = 0; b < 4; b++)
                if (ws[b]) ref_mem[a[10:2]][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [3:0]  ws;
        int order[$];
        int bad_v, bad_r, bad_e, wc, wv, max_wait, diffs;
        logic cr, vr, cs_prev, vs_prev, handoff_chk;

        for (int i = 0; i < 512; i++) mem_arr[i] = {16'(i), 16'hA5C3 ^ 16'(i)};
        mem_arr[0] = 32'h0080_0113;
        for (int i = 0; i < 512; i++) ref_mem[i] = mem_arr[i];

        // Reset values
        do_reset();
        chk("rst_valid", 32'(mem_if.mem_valid), 32'd0);
        chk("rst_instr", 32'(mem_if.mem_instr), 32'd0);
        chk("rst_addr",  mem_if.mem_addr, 32'd0);
        chk("rst_wdata", mem_if.mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
        chk("rst_ready", 32'({cpu_if.mem_ready, vec_if.mem_ready, timeout_err}), 32'd0);

        // mem_ready while idle must be ignored
        force_ready = 1'b1;
        tick();
        chk("idle_ready", 32'({cpu_if.mem_ready, vec_if.mem_ready, mem_if.mem_valid}), 32'd0);
        force_ready = 1'b0;

        // Core alone fetches address 0
        drive_cpu(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
        tick();
        chk("fetch_valid", 32'(mem_if.mem_valid), 32'd1);
        chk("fetch_instr", 32'(mem_if.mem_instr), 32'd1);
        chk("fetch_early", 32'(cpu_if.mem_ready), 32'd0);
        tick();
        chk("fetch_ready", 32'(cpu_if.mem_ready), 32'd1);
        chk("fetch_rdata", cpu_if.mem_rdata, 32'h0080_0113);
        chk("fetch_vready", 32'(vec_if.mem_ready), 32'd0);
        tick();
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("fetch_done", 32'(mem_if.mem_valid), 32'd0);

        // Simultaneous core read and vector write: core first, no idle gap
        do_reset();
        drive_cpu(1'b1, 1'b0, 32'h190, 32'h0, 4'h0);
        drive_vec(1'b1, 32'h320, 32'h1234_5678, 4'hF);
        tick();
        chk("tie_addr", mem_if.mem_addr, 32'h190);
        tick();
        chk("tie_cpu_ready", 32'(cpu_if.mem_ready), 32'd1);
        chk("tie_cpu_rdata", cpu_if.mem_rdata, mem_arr[100]);
        tick();
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("handoff_valid", 32'(mem_if.mem_valid), 32'd1);
        chk("handoff_addr", mem_if.mem_addr, 32'h320);
        chk("handoff_wdata", mem_if.mem_wdata, 32'h1234_5678);
        chk("handoff_wstrb", 32'(mem_if.mem_wstrb), 32'hF);
        tick();
        chk("vec_ready", 32'(vec_if.mem_ready), 32'd1);
        chk("word200", mem_arr[200], 32'h1234_5678);
        drive_vec(1'b0, 32'h0, 32'h0, 4'h0);

        // Both valid continuously: CPU, VEC, CPU, VEC
        do_reset();
        drive_cpu(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        drive_vec(1'b1, 32'h20, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (cpu_if.mem_ready) order.push_back(0);
            if (vec_if.mem_ready) order.push_back(1);
        end
        chk("rr_count", 32'(order.size()), 32'd4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            chk("rr_seq", 32'(order[k]), 32'(k % 2));

`ifdef MEM_ARB_TIMEOUT_EN
        // Unanswered vector read is forced to complete on the TO-th cycle
        do_reset();
        drive_vec(1'b1, 32'd2048, 32'h0, 4'h0);
        tick();
        drive_cpu(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        bad_r = 0;
        for (int k = 0; k < TO - 2; k++) begin
            tick();
            if (vec_if.mem_ready || cpu_if.mem_ready || timeout_err) bad_r++;
        end
        chk("to_early", 32'(bad_r), 32'd0);
        tick();
        chk("to_vready", 32'(vec_if.mem_ready), 32'd1);
        chk("to_rdata", vec_if.mem_rdata, 32'h0);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_cready", 32'(cpu_if.mem_ready), 32'd0);
        tick();
        drive_vec(1'b0, 32'h0, 32'h0, 4'h0);
        chk("to_next_addr", mem_if.mem_addr, 32'h40);
        chk("to_err_pulse", 32'(timeout_err), 32'd0);
        tick();
        chk("to_cpu_ready", 32'(cpu_if.mem_ready), 32'd1);
        chk("to_cpu_rdata", cpu_if.mem_rdata, mem_arr[16]);
`else
        // Without the watchdog an unanswered read waits indefinitely
        do_reset();
        drive_vec(1'b1, 32'd2048, 32'h0, 4'h0);
        tick();
        bad_v = 0; bad_r = 0; bad_e = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (!mem_if.mem_valid) bad_v++;
            if (vec_if.mem_ready || cpu_if.mem_ready) bad_r++;
            if (timeout_err) bad_e++;
        end
        chk("hang_valid", 32'(bad_v), 32'd0);
        chk("hang_ready", 32'(bad_r), 32'd0);
        chk("hang_err", 32'(bad_e), 32'd0);
`endif

        // Reset in the middle of a vector grant
        do_reset();
        drive_vec(1'b1, 32'h80, 32'h0, 4'h0);
        tick();
        #1 reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(mem_if.mem_valid), 32'd0);
        chk("midrst_addr", mem_if.mem_addr, 32'h0);
        chk("midrst_ready", 32'({cpu_if.mem_ready, vec_if.mem_ready, timeout_err}), 32'd0);
        tick();
        reset = 1'b0;
        drive_cpu(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        drive_vec(1'b1, 32'h104, 32'h0, 4'h0);
        tick();
        chk("postrst_first", mem_if.mem_addr, 32'h100);

        // Randomized traffic against the transfer-level reference
        do_reset();
        for (int i = 0; i < 512; i++) ref_mem[i] = mem_arr[i];
        cs_prev = 1'b0; vs_prev = 1'b0; handoff_chk = 1'b0;
        wc = 0; wv = 0; max_wait = 0; exp_next = -1;
        for (int k = 0; k < 640; k++) begin
            tick();
            cr = cpu_if.mem_ready;
            vr = vec_if.mem_ready;
            chk("one_ready", 32'(cr & vr), 32'd0);
            chk("no_timeout", 32'(timeout_err), 32'd0);
            if (handoff_chk) chk("rand_handoff", 32'(mem_if.mem_valid), 32'd1);
            handoff_chk = 1'b0;
            if (cr) begin
                chk("cpu_req_held", 32'(cpu_if.mem_valid & ~cs_prev), 32'd1);
                on_ready(0, cpu_if.mem_addr, cpu_if.mem_wdata, cpu_if.mem_wstrb, cpu_if.mem_rdata);
            end
            if (vr) begin
                chk("vec_req_held", 32'(vec_if.mem_valid & ~vs_prev), 32'd1);
                on_ready(1, vec_if.mem_addr, vec_if.mem_wdata, vec_if.mem_wstrb, vec_if.mem_rdata);
            end
            if (cs_prev || (!cpu_if.mem_valid && $urandom_range(0, 2) == 0)) begin
                rand_req(a, wd, ws);
                drive_cpu(k < 600 && $urandom_range(0, 1) == 1, 1'($urandom), a, wd, ws);
            end
            if (vs_prev || (!vec_if.mem_valid && $urandom_range(0, 2) == 0)) begin
                rand_req(a, wd, ws);
                drive_vec(k < 600 && $urandom_range(0, 1) == 1, a, wd, ws);
            end
            if (cr) begin
                exp_next = vec_if.mem_valid ? 1 : -1;
                handoff_chk = vec_if.mem_valid;
            end
            if (vr) begin
                exp_next = cpu_if.mem_valid ? 0 : -1;
                handoff_chk = cpu_if.mem_valid;
            end
            wc = (cpu_if.mem_valid && !cr) ? wc + 1 : 0;
            wv = (vec_if.mem_valid && !vr) ? wv + 1 : 0;
            if (wc > max_wait) max_wait = wc;
            if (wv > max_wait) max_wait = wv;
            cs_prev = cr;
            vs_prev = vr;
        end
        chk("max_wait", 32'(max_wait <= 8), 32'd1);
        chk("drained", 32'(cpu_if.mem_valid | vec_if.mem_valid), 32'd0);
        diffs = 0;
        for (int i = 0; i < 512; i++) if (mem_arr[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 32'(diffs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
